// File: rtl/mac_seq_ctrl.sv
// Command sequencer for a MAC wrapper: configures the MAC, streams N operand
// pairs into it, reads the accumulated result back and returns it to the requester.
module mac_seq_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [7:0]        cmd_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              busy,
    output logic              mac_enable,
    output logic              mac_valid,
    output logic              mac_read,
    output logic              mac_cfg,
    output logic              mac_mode,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_out,
    input  logic              mac_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_RUN,
        S_READ,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_err_q, res_err_d;
    logic [7:0]        cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        cmd_ready  = 1'b0;
        op_ready   = 1'b0;
        res_valid  = 1'b0;
        mac_enable = 1'b0;
        mac_valid  = 1'b0;
        mac_read   = 1'b0;
        mac_cfg    = 1'b0;
        mac_mode   = 1'b0;
        mac_a      = '0;
        mac_b      = '0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    mode_d   = cmd_mode;
                    len_d    = cmd_len;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    // An empty command answers with an error and never touches the MAC.
                    if (cmd_len == 8'd0) begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_CFG;
                    end
                end
            end
            S_CFG: begin
                mac_cfg  = 1'b1;
                mac_mode = mode_q;
                state_d  = S_RUN;
            end
            S_RUN: begin
                op_ready   = 1'b1;
                mac_enable = 1'b1;
                mac_mode   = mode_q;
                mac_valid  = op_valid;
                mac_a      = op_a;
                mac_b      = op_b;
                sticky_d   = sticky_q | mac_error;
                if (op_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                mac_enable = 1'b1;
                mac_read   = 1'b1;
                mac_mode   = mode_q;
                res_data_d = mac_out;
                res_err_d  = sticky_q | mac_error;
                state_d    = S_RESP;
            end
            S_RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign res_data = res_data_q;
    assign res_err  = res_err_q;

endmodule
